// File: rtl/doodle_motion_ctrl.sv
// Doodle motion controller: owns doodle position, signed vertical velocity and
// jump state. Velocity-based jumps with gravity, spring pads, horizontal
// wrap-around and death when the doodle drops below the camera.
module doodle_motion_ctrl #(
  parameter int X_W          = 10,
  parameter int Y_W          = 16,
  parameter int V_W          = 8,
  parameter int SCREEN_WIDTH = 640,
  parameter int START_Y      = 16,
  parameter int H_SPEED      = 2,
  parameter int GRAVITY      = 1,
  parameter int JUMP_VEL     = 12,
  parameter int BOOST_VEL    = 24,
  parameter int MAX_FALL     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic                  start,
  input  logic                  left,
  input  logic                  right,
  input  logic                  land_valid,
  input  logic [Y_W-1:0]        land_y,
  input  logic                  boost,
  input  logic [Y_W-1:0]        cam_y,
  output logic [X_W-1:0]        doodle_x,
  output logic [Y_W-1:0]        doodle_y,
  output logic signed [V_W-1:0] vel_y,
  output logic                  falling,
  output logic                  dead,
  output logic                  jump_pulse,
  output logic [Y_W-1:0]        max_y
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RISING  = 2'd1,
    FALLING = 2'd2,
    DEAD    = 2'd3
  } state_t;

  // Two guard bits on the vertical sum: one for sign, one so a large upward
  // step can never alias into a negative value.
  localparam int YS_W = Y_W + 2;

  localparam logic [X_W-1:0]        X_INIT   = X_W'(SCREEN_WIDTH / 2);
  localparam logic [Y_W-1:0]        Y_INIT   = Y_W'(START_Y);
  localparam logic signed [V_W-1:0] V_JUMP   = V_W'(JUMP_VEL);
  localparam logic signed [V_W-1:0] V_BOOST  = V_W'(BOOST_VEL);
  localparam logic signed [V_W-1:0] V_MIN    = V_W'(-MAX_FALL);
  localparam logic signed [V_W:0]   V_MIN_W  = (V_W+1)'(-MAX_FALL);
  localparam logic signed [V_W:0]   V_GRAV_W = (V_W+1)'(GRAVITY);

  state_t                  state_reg, state_next;
  logic [X_W-1:0]          x_reg, x_next, x_move;
  logic [Y_W-1:0]          y_reg, y_next;
  logic [Y_W-1:0]          max_reg, max_next;
  logic signed [V_W-1:0]   vel_reg, vel_next, vel_grav;
  logic                    pulse_reg, pulse_next;

  logic signed [YS_W-1:0]  y_sum;
  logic signed [V_W:0]     vel_dec;
  logic [X_W:0]            x_right;
  logic                    y_below_zero;
  logic                    y_below_cam;
  logic                    vel_nonpos;

  // Candidate vertical position and gravity-applied, fall-clamped velocity.
  assign y_sum        = $signed({2'b00, y_reg}) + $signed({{(YS_W-V_W){vel_reg[V_W-1]}}, vel_reg});
  assign vel_dec      = $signed({vel_reg[V_W-1], vel_reg}) - V_GRAV_W;
  assign vel_grav     = (vel_dec < V_MIN_W) ? V_MIN : vel_dec[V_W-1:0];
  assign vel_nonpos   = vel_grav[V_W-1] || (vel_grav == '0);
  assign y_below_zero = y_sum[YS_W-1];
  assign y_below_cam  = (y_sum[Y_W:0] < {1'b0, cam_y});
  assign x_right      = {1'b0, x_reg} + (X_W+1)'(H_SPEED);

  // Horizontal step with wrap-around in both directions; opposing keys cancel.
  always_comb begin
    x_move = x_reg;
    if (right && !left) begin
      if (x_right >= (X_W+1)'(SCREEN_WIDTH))
        x_move = X_W'(x_right - (X_W+1)'(SCREEN_WIDTH));
      else
        x_move = x_right[X_W-1:0];
    end else if (left && !right) begin
      if (x_reg < X_W'(H_SPEED))
        x_move = x_reg + X_W'(SCREEN_WIDTH - H_SPEED);
      else
        x_move = x_reg - X_W'(H_SPEED);
    end
  end

  // Next-state and next-value logic; everything holds unless tick is high.
  always_comb begin
    state_next = state_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    vel_next   = vel_reg;
    max_next   = max_reg;
    pulse_next = 1'b0;
    if (tick) begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_next = RISING;
            vel_next   = V_JUMP;
            pulse_next = 1'b1;
          end
        end
        RISING: begin
          x_next   = x_move;
          y_next   = y_sum[Y_W-1:0];
          vel_next = vel_grav;
          if (vel_nonpos)
            state_next = FALLING;
        end
        FALLING: begin
          x_next = x_move;
          if (land_valid) begin
            // A landing rescues the doodle even on a tick that would kill it.
            y_next     = land_y;
            vel_next   = boost ? V_BOOST : V_JUMP;
            pulse_next = 1'b1;
            state_next = RISING;
          end else if (y_below_zero) begin
            y_next     = '0;
            vel_next   = vel_grav;
            state_next = DEAD;
          end else begin
            y_next   = y_sum[Y_W-1:0];
            vel_next = vel_grav;
            if (y_below_cam)
              state_next = DEAD;
          end
        end
        DEAD: begin
          if (start) begin
            state_next = IDLE;
            x_next     = X_INIT;
            y_next     = Y_INIT;
            vel_next   = '0;
            max_next   = Y_INIT;
          end
        end
        default: state_next = IDLE;
      endcase
    end
    if (y_next > max_next)
      max_next = y_next;
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      x_reg     <= X_INIT;
      y_reg     <= Y_INIT;
      vel_reg   <= '0;
      max_reg   <= Y_INIT;
      pulse_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      vel_reg   <= vel_next;
      max_reg   <= max_next;
      pulse_reg <= pulse_next;
    end
  end

  assign doodle_x   = x_reg;
  assign doodle_y   = y_reg;
  assign vel_y      = vel_reg;
  assign max_y      = max_reg;
  assign jump_pulse = pulse_reg;
  assign falling    = (state_reg == FALLING);
  assign dead       = (state_reg == DEAD);

endmodule

// File: tb/tb_doodle_motion_ctrl.sv
// Self-checking bench for doodle_motion_ctrl: a behavioural model predicts the
// outputs of every cycle into a scoreboard queue, which is popped and compared
// one cycle later, plus directed checks on the key trajectory points.
module tb_doodle_motion_ctrl;

  logic        clk = 1'b0;
  logic        reset, tick, start, left, right, land_valid, boost;
  logic [15:0] land_y, cam_y;
  logic [9:0]  doodle_x;
  logic [15:0] doodle_y, max_y;
  logic signed [7:0] vel_y;
  logic        falling, dead, jump_pulse;

  always #5 clk = ~clk;

  doodle_motion_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .start      (start),
    .left       (left),
    .right      (right),
    .land_valid (land_valid),
    .land_y     (land_y),
    .boost      (boost),
    .cam_y      (cam_y),
    .doodle_x   (doodle_x),
    .doodle_y   (doodle_y),
    .vel_y      (vel_y),
    .falling    (falling),
    .dead       (dead),
    .jump_pulse (jump_pulse),
    .max_y      (max_y)
  );

  typedef struct {
    int x;
    int y;
    int v;
    int st;
    int p;
    int mx;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Model state: 0 idle, 1 rising, 2 falling, 3 dead.
  int m_state, m_x, m_y, m_v, m_max, m_p;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic defaults();
    reset = 1'b0; tick = 1'b1; start = 1'b0; left = 1'b0; right = 1'b0;
    land_valid = 1'b0; land_y = '0; boost = 1'b0; cam_y = '0;
  endtask

  // Reference behaviour for one clock edge, from the current inputs.
  task automatic model_step();
    int ny, nv;
    m_p = 0;
    if (reset) begin
      m_state = 0; m_x = 320; m_y = 16; m_v = 0; m_max = 16;
    end else if (tick) begin
      case (m_state)
        0: if (start) begin m_state = 1; m_v = 12; m_p = 1; end
        1, 2: begin
          ny = m_y + m_v;
          nv = m_v - 1;
          if (nv < -16) nv = -16;
          if (right && !left)      m_x = (m_x + 2) % 640;
          else if (left && !right) m_x = (m_x + 638) % 640;
          if (m_state == 1) begin
            m_y = ny; m_v = nv;
            if (nv <= 0) m_state = 2;
          end else if (land_valid) begin
            m_y = int'(land_y); m_v = boost ? 24 : 12; m_p = 1; m_state = 1;
          end else if (ny < 0) begin
            m_y = 0; m_v = nv; m_state = 3;
          end else begin
            m_y = ny; m_v = nv;
            if (ny < int'(cam_y)) m_state = 3;
          end
        end
        default: if (start) begin
          m_state = 0; m_x = 320; m_y = 16; m_v = 0; m_max = 16;
        end
      endcase
    end
    if (m_y > m_max) m_max = m_y;
  endtask

  // One clock: predict, push, clock, pop and compare.
  task automatic step();
    exp_t e;
    model_step();
    e.x = m_x; e.y = m_y; e.v = m_v; e.st = m_state; e.p = m_p; e.mx = m_max;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    if (sb_q.size() == 0) begin
      check("sb_empty", 0, 1);
    end else begin
      e = sb_q.pop_front();
      check("x", doodle_x, e.x);
      check("y", doodle_y, e.y);
      check("vel", $signed(vel_y), e.v);
      check("falling", falling, (e.st == 2) ? 1 : 0);
      check("dead", dead, (e.st == 3) ? 1 : 0);
      check("pulse", jump_pulse, e.p);
      check("max_y", max_y, e.mx);
    end
    $display("cyc %0d rst=%0d tick=%0d st=%0b%0b x=%0d y=%0d v=%0d p=%0d max=%0d",
             cyc, reset, tick, dead, falling, doodle_x, doodle_y, vel_y, jump_pulse, max_y);
  endtask

  task automatic tick_until_state(input int st, input string tag);
    int n = 0;
    while (m_state != st && n < 300) begin
      step();
      n++;
    end
    if (m_state != st) check(tag, m_state, st);
  endtask

  task automatic fall_until(input int ty, input int tv, input string tag);
    int n = 0;
    while (!(m_y == ty && m_v == tv) && n < 300) begin
      step();
      n++;
    end
    if (!(m_y == ty && m_v == tv)) check(tag, m_y, ty);
  endtask

  initial begin
    int pulses;
    int hold_x, hold_y, hold_v;
    int n;

    defaults();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check("rst_x", doodle_x, 320);
    check("rst_y", doodle_y, 16);
    check("rst_vel", $signed(vel_y), 0);
    check("rst_max", max_y, 16);
    check("rst_pulse", jump_pulse, 0);

    // First jump: launch then 12 ticks up to the apex.
    pulses = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    pulses += int'(jump_pulse);
    check("start_pulse", jump_pulse, 1);
    for (int i = 1; i <= 12; i++) begin
      step();
      pulses += int'(jump_pulse);
      if (i == 1) check("y_tick1", doodle_y, 28);
    end
    check("apex_y", doodle_y, 94);
    check("apex_vel", $signed(vel_y), 0);
    check("apex_falling", falling, 1);
    check("apex_max", max_y, 94);
    check("one_pulse", pulses, 1);

    // Normal landing, then boost landing; landings are ignored while rising.
    n = 0;
    while (m_y > 60 && n < 50) begin step(); n++; end
    land_valid = 1'b1; land_y = 16'd48;
    step();
    check("land_y", doodle_y, 48);
    check("land_vel", $signed(vel_y), 12);
    check("land_rising", falling, 0);
    check("land_pulse", jump_pulse, 1);
    land_y = 16'd5;
    step(); step(); step();
    land_valid = 1'b0;
    tick_until_state(2, "to_fall1");
    land_valid = 1'b1; land_y = 16'd48; boost = 1'b1;
    step();
    check("boost_vel", $signed(vel_y), 24);
    check("boost_pulse", jump_pulse, 1);
    defaults();
    step(); step();

    // Physics frozen while tick is low, whatever the other inputs do.
    hold_x = m_x; hold_y = m_y; hold_v = m_v;
    tick = 1'b0;
    for (int i = 0; i < 50; i++) begin
      start = 1'($urandom_range(0, 1));
      left = 1'($urandom_range(0, 1));
      right = 1'($urandom_range(0, 1));
      land_valid = 1'($urandom_range(0, 1));
      land_y = 16'($urandom_range(0, 200));
      step();
    end
    check("hold_x", doodle_x, hold_x);
    check("hold_y", doodle_y, hold_y);
    check("hold_vel", $signed(vel_y), hold_v);
    defaults();

    // Horizontal wrap, bouncing on a platform at y=16 to stay alive.
    right = 1'b1; land_valid = 1'b1; land_y = 16'd16;
    n = 0;
    while (m_x != 638 && n < 400) begin step(); n++; end
    check("x_638", doodle_x, 638);
    step();
    check("wrap_right", doodle_x, 0);
    right = 1'b0; left = 1'b1;
    step();
    check("wrap_left", doodle_x, 638);
    right = 1'b1;
    step();
    check("both_hold", doodle_x, 638);
    defaults();

    // Camera death, with and without a rescuing landing.
    tick_until_state(2, "to_fall2");
    land_valid = 1'b1; land_y = 16'd42;
    step();
    land_valid = 1'b0;
    fall_until(105, -6, "to_105a");
    cam_y = 16'd100; land_valid = 1'b1;
    step();
    check("rescue_dead", dead, 0);
    check("rescue_y", doodle_y, 42);
    land_valid = 1'b0; cam_y = 16'd0;
    fall_until(105, -6, "to_105b");
    cam_y = 16'd100;
    step();
    check("cam_y", doodle_y, 99);
    check("cam_dead", dead, 1);
    cam_y = 16'd0;
    right = 1'b1; land_valid = 1'b1;
    step(); step(); step();
    defaults();
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_x", doodle_x, 320);
    check("restart_y", doodle_y, 16);
    check("restart_dead", dead, 0);
    check("restart_max", max_y, 16);
    check("restart_pulse", jump_pulse, 0);

    // Long fall from a boost apex: velocity clamps, ground kills.
    start = 1'b1;
    step();
    start = 1'b0;
    tick_until_state(2, "to_fall3");
    land_valid = 1'b1; land_y = 16'd198; boost = 1'b1;
    step();
    defaults();
    tick_until_state(2, "to_apex");
    check("boost_apex", doodle_y, 498);
    for (int i = 0; i < 30; i++) step();
    check("clamp_vel", $signed(vel_y), -16);
    check("clamp_y", doodle_y, 154);
    fall_until(10, -16, "to_10");
    step();
    check("ground_y", doodle_y, 0);
    check("ground_dead", dead, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    check("idle_x", doodle_x, 320);
    check("idle_y", doodle_y, 16);

    // Reset in the middle of a rise, overriding a simultaneous start.
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    reset = 1'b1; start = 1'b1;
    step();
    check("mid_rst_y", doodle_y, 16);
    check("mid_rst_vel", $signed(vel_y), 0);
    check("mid_rst_max", max_y, 16);
    check("mid_rst_x", doodle_x, 320);
    defaults();
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
